aes_key_expander: RTL and testbench

- Iterative, parametrised AES key-schedule engine. Replaces the fixed per-round combinational key-schedule slices.
- Supports AES-128, AES-192 and AES-256, selected at run time.
- Generates one 32-bit expanded word per clock from a single S-box-word datapath.
- Packs every four words into a 128-bit round key and streams the keys out, in order, over a valid/ready handshake with backpressure. Sits between the key register and the round datapath / round-key store.

---
 rtl/aes_key_expander_if.sv | 27 ++
 rtl/aes_key_expander.sv | 243 ++++++++++++++++++++++++
 tb/tb_aes_key_expander.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// Request/stream bundle for the AES key expander: start/mode/key in, round keys out with valid/ready.
interface aes_key_expander_if #(
  parameter int unsigned MAX_NK = 8,
  parameter int unsigned IDX_W  = 4
);
  logic                  start;
  logic [1:0]            key_len;
  logic [32*MAX_NK-1:0]  key_in;
  logic                  busy;
  logic                  rk_valid;
  logic                  rk_ready;
  logic [127:0]          rk_data;
  logic [IDX_W-1:0]      rk_idx;
  logic                  rk_last;
  logic                  done;
  logic                  err;

  modport master (
    output start, key_len, key_in, rk_ready,
    input  busy, rk_valid, rk_data, rk_idx, rk_last, done, err
  );

  modport slave (
    input  start, key_len, key_in, rk_ready,
    output busy, rk_valid, rk_data, rk_idx, rk_last, done, err
  );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one word per clock, streams 128-bit round keys.
// Optional round-key store with combinational read port under macro AES_KEY_EXP_STORE_EN.
module aes_key_expander #(
  parameter int unsigned MAX_NK = 8,
  parameter int unsigned IDX_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef AES_KEY_EXP_STORE_EN
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [127:0]       rd_key,
`endif
  aes_key_expander_if.slave  bus
);

  localparam int unsigned I_W    = 6;
  localparam int unsigned NR_MAX = MAX_NK + 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // AES S-box, entry 0 in the top byte so the lookup index is ~x
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[~x[31:24]], SBOX[~x[23:16]], SBOX[~x[15:8]], SBOX[~x[7:0]]};
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]                   state_q, state_d;
  logic                         busy_q, busy_d;
  logic                         rk_valid_q, rk_valid_d;
  logic                         rk_last_q, rk_last_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic [127:0]                 rk_data_q, rk_data_d;
  logic [IDX_W-1:0]             rk_idx_q, rk_idx_d;
  logic [1:0]                   key_len_q, key_len_d;
  logic [MAX_NK-1:0][31:0]      key_q, key_d;
  logic [MAX_NK-1:0][31:0]      hist_q, hist_d;
  logic [95:0]                  acc_q, acc_d;
  logic [I_W-1:0]               i_q, i_d;
  logic [2:0]                   pos_q, pos_d;
  logic [7:0]                   rc_q, rc_d;
  logic [IDX_W-1:0]             r_q, r_d;

  logic [3:0]                   nk;
  logic [IDX_W-1:0]             nr;
  logic                         key_phase;
  logic [31:0]                  kw, wnk, temp, word;
  logic                         legal_c;
  logic                         accept_c;

  assign legal_c  = (bus.key_len != 2'b11) && (nk_of(bus.key_len) <= 4'(MAX_NK));
  assign accept_c = (state_q == S_HOLD) && bus.rk_ready;

  // Next expanded word w[i] from the latched key or the Nk-word history
  always_comb begin
    nk        = nk_of(key_len_q);
    nr        = IDX_W'(nk) + IDX_W'(6);
    key_phase = (i_q < I_W'(nk));
    kw        = '0;
    for (int j = 0; j < int'(MAX_NK); j++) begin
      if (i_q == I_W'(j)) kw = key_q[MAX_NK-1-j];
    end
    wnk = '0;
    for (int j = 0; j < int'(MAX_NK); j++) begin
      if (nk == 4'(j + 1)) wnk = hist_q[j];
    end
    temp = hist_q[0];
    if (pos_q == 3'd0) begin
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc_q, 24'h0};
    end else if ((nk == 4'd8) && (pos_q == 3'd4)) begin
      temp = sub_word(temp);
    end
    word = key_phase ? kw : (wnk ^ temp);
  end

  // Control: next state and next values of all registers
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    key_len_d  = key_len_q;
    key_d      = key_q;
    hist_d     = hist_q;
    acc_d      = acc_q;
    i_d        = i_q;
    pos_d      = pos_q;
    rc_d       = rc_q;
    r_d        = r_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (legal_c) begin
            state_d   = S_GEN;
            busy_d    = 1'b1;
            key_len_d = bus.key_len;
            key_d     = bus.key_in;
            i_d       = '0;
            pos_d     = '0;
            rc_d      = 8'h01;
            r_d       = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GEN: begin
        hist_d = {hist_q[MAX_NK-2:0], word};
        acc_d  = {acc_q[63:0], word};
        i_d    = i_q + I_W'(1);
        pos_d  = (pos_q == 3'(nk - 4'd1)) ? 3'd0 : pos_q + 3'd1;
        if ((pos_q == 3'd0) && !key_phase) rc_d = xtime(rc_q);
        if (i_q[1:0] == 2'b11) begin
          rk_data_d  = {acc_q, word};
          rk_idx_d   = r_q;
          rk_valid_d = 1'b1;
          rk_last_d  = (r_q == nr);
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.rk_ready) begin
          rk_valid_d = 1'b0;
          rk_last_d  = 1'b0;
          if (r_q == nr) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            r_d     = r_q + IDX_W'(1);
            state_d = S_GEN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      key_len_q  <= '0;
      key_q      <= '0;
      hist_q     <= '0;
      acc_q      <= '0;
      i_q        <= '0;
      pos_q      <= '0;
      rc_q       <= '0;
      r_q        <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
      key_len_q  <= key_len_d;
      key_q      <= key_d;
      hist_q     <= hist_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      pos_q      <= pos_d;
      rc_q       <= rc_d;
      r_q        <= r_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_last  = rk_last_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_idx   = rk_idx_q;

`ifdef AES_KEY_EXP_STORE_EN
  // Accepted round keys kept by index for reverse-order (decryption) reads
  logic [127:0] store_q [NR_MAX+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= int'(NR_MAX); j++) store_q[j] <= '0;
    end else if ((state_q == S_IDLE) && bus.start && legal_c) begin
      for (int j = 0; j <= int'(NR_MAX); j++) store_q[j] <= '0;
    end else if (accept_c) begin
      for (int j = 0; j <= int'(NR_MAX); j++) begin
        if (rk_idx_q == IDX_W'(j)) store_q[j] <= rk_data_q;
      end
    end
  end

  always_comb begin
    rd_key = '0;
    for (int j = 0; j <= int'(NR_MAX); j++) begin
      if (rd_idx == IDX_W'(j)) rd_key = store_q[j];
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept_c;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: reference key schedule (GF-derived S-box) vs streamed keys.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expander_if #(.MAX_NK(8), .IDX_W(4)) bus ();
  aes_key_expander_if #(.MAX_NK(4), .IDX_W(4)) bus4 ();

`ifdef AES_KEY_EXP_STORE_EN
  logic [127:0] rd_key8, rd_key4;
  aes_key_expander #(.MAX_NK(8), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rd_idx(4'd0), .rd_key(rd_key8), .bus(bus));
  aes_key_expander #(.MAX_NK(4), .IDX_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rd_idx(4'd0), .rd_key(rd_key4), .bus(bus4));
`else
  aes_key_expander #(.MAX_NK(8), .IDX_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  aes_key_expander #(.MAX_NK(4), .IDX_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
`endif

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] got [16];
  int           checks = 0;
  int           failures = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdef_fedcba9876543210};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeef_cafef00d};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from the field inverse plus affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic model_push(input logic [1:0] kl, input logic [255:0] key);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    exp_t e;
    nk = 4 + 2 * int'(kl);
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.idx  = 4'(r);
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.last = (r == nr);
      exp_q.push_back(e);
    end
  endtask

  // One full expansion; optional stall on one key and an ignored start/key change while busy
  task automatic run(input logic [1:0] kl, input logic [255:0] key, input int stall_idx, input int inj_cycle);
    int cyc, first, k1_cyc, stall_n, keys, done_cyc, nr;
    bit fin;
    exp_t e;
    nr = 10 + 2 * int'(kl);
    model_push(kl, key);
    for (int j = 0; j < 16; j++) got[j] = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.key_len = kl; bus.key_in = key; bus.rk_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 128'(bus.busy), 128'(1));
    cyc = 0; first = -1; k1_cyc = -1; stall_n = 0; keys = 0; done_cyc = -1; fin = 0;
    while (!fin && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == inj_cycle) begin
        bus.start = 1'b1; bus.key_len = 2'b00; bus.key_in = ~key;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        fin = 1;
        check("done_cycle", 128'(cyc), 128'(done_cyc));
        check("busy_at_done", 128'(bus.busy), 128'(0));
        check("valid_at_done", 128'(bus.rk_valid), 128'(0));
      end else if (bus.rk_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_key", 128'(1), 128'(0));
          fin = 1;
        end else begin
          e = exp_q[0];
          if (first < 0) begin
            first = cyc;
            check("first_key_latency", 128'(cyc), 128'(4));
          end
          if (bus.rk_idx == 4'd1 && k1_cyc < 0) begin
            k1_cyc = cyc;
            check("key_gap", 128'(cyc - first), 128'(5));
          end
          check("rk_data", bus.rk_data, e.data);
          check("rk_idx", 128'(bus.rk_idx), 128'(e.idx));
          check("rk_last", 128'(bus.rk_last), 128'(e.last));
          if (int'(bus.rk_idx) == stall_idx && stall_n < 7) begin
            bus.rk_ready = 1'b0;
            stall_n++;
          end else begin
            bus.rk_ready = 1'b1;
            got[bus.rk_idx] = bus.rk_data;
            keys++;
            void'(exp_q.pop_front());
            if (e.last) done_cyc = cyc + 1;
          end
        end
      end
    end
    check("run_finished", 128'(fin), 128'(1));
    check("key_count", 128'(keys), 128'(nr + 1));
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    @(negedge clk);
    bus.key_in = '0;
    check("done_pulse_width", 128'(bus.done), 128'(0));
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.key_len = 2'b00; bus.key_in = '0; bus.rk_ready = 1'b1;
    bus4.start = 1'b0; bus4.key_len = 2'b00; bus4.key_in = '0; bus4.rk_ready = 1'b1;
    build_sbox();
    repeat (2) @(negedge clk);
    check("reset_flags", 128'({bus.busy, bus.rk_valid, bus.rk_last, bus.done, bus.err, bus.rk_idx}), 128'(0));
    check("reset_data", bus.rk_data, 128'(0));
    rst_n = 1'b1;

    run(2'b00, K128, -1, -1);
    check("aes128_k0", got[0], K128[255:128]);
    check("aes128_k1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run(2'b01, K192, -1, 7);
    check("aes192_k12", got[12], 128'he98ba06f448c773c8ecc720401002202);

    run(2'b10, K256, -1, -1);
    check("aes256_k14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

    run(2'b00, K128, 3, -1);
    check("stall_k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Illegal modes: key_len=11 everywhere, AES-256 on a MAX_NK=4 build
    @(negedge clk);
    bus.start = 1'b1; bus.key_len = 2'b11; bus.key_in = K128;
    bus4.start = 1'b1; bus4.key_len = 2'b10; bus4.key_in = K128[255:128];
    @(negedge clk);
    bus.start = 1'b0; bus4.start = 1'b0;
    check("err_illegal", 128'(bus.err), 128'(1));
    check("busy_illegal", 128'(bus.busy), 128'(0));
    check("err_nk_gt_max", 128'(bus4.err), 128'(1));
    check("busy_nk_gt_max", 128'(bus4.busy), 128'(0));
    @(negedge clk);
    check("err_pulse_width", 128'({bus.err, bus4.err}), 128'(0));
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rk_valid || bus4.rk_valid || bus.busy) n++;
    end
    check("no_key_after_err", 128'(n), 128'(0));

    // Asynchronous abort mid-generation at word 17
    @(negedge clk);
    bus.start = 1'b1; bus.key_len = 2'b00; bus.key_in = K128; bus.rk_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.rk_valid && bus.rk_idx == 4'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx3", 128'(n < 100), 128'(1));
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_flags", 128'({bus.busy, bus.rk_valid, bus.rk_last, bus.done, bus.err, bus.rk_idx}), 128'(0));
    check("abort_data", bus.rk_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    run(2'b00, K128, -1, -1);
    check("post_abort_k0", got[0], K128[255:128]);
    check("post_abort_k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
